// File: rtl/mul_issue_sched.sv
`default_nettype none
// ============================================================================
// Module  : mul_issue_sched
// Brief   : Issue gate for a fixed-latency multiplier plus MUL/ALU writeback
//           merge onto the single register-file write port.
// Rev     : 1.0  initial release
// ============================================================================
module mul_issue_sched #(
    parameter int MUL_LATENCY = 6,
    parameter int REG_ADDR    = 5,
    parameter int WD_SIZE     = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                dec_valid_i,
    input  logic                dec_is_mul_i,
    input  logic                dec_we_i,
    input  logic [REG_ADDR-1:0] dec_rd_i,
    input  logic [REG_ADDR-1:0] dec_rs1_i,
    input  logic [REG_ADDR-1:0] dec_rs2_i,
    output logic                stall_o,
    output logic                mul_issue_o,
    input  logic [WD_SIZE-1:0]  alu_result_i,
    input  logic                mul_valid_i,
    input  logic [WD_SIZE-1:0]  mul_result_i,
    output logic                wb_valid_o,
    output logic [REG_ADDR-1:0] wb_rd_o,
    output logic [WD_SIZE-1:0]  wb_data_o,
    output logic                mul_busy_o,
    output logic                error_o
);
    localparam int LAST = MUL_LATENCY - 1;

    logic [MUL_LATENCY-1:0] slot_v;
    logic [REG_ADDR-1:0]    slot_rd [MUL_LATENCY];
    logic                   alu_v;
    logic [REG_ADDR-1:0]    alu_rd;
    logic                   error_q;

    logic raw;
    logic waw;
    logic port;
    logic writes_rd;
    logic stall;
    logic issue;
    logic mul_go;
    logic alu_go;
    logic wb_valid;

    always_comb begin
        raw       = 1'b0;
        waw       = 1'b0;
        writes_rd = dec_is_mul_i | dec_we_i;
        for (int i = 0; i < MUL_LATENCY; i++) begin
            if (slot_v[i]) begin
                if (dec_rs1_i != '0 && dec_rs1_i == slot_rd[i]) raw = 1'b1;
                if (dec_rs2_i != '0 && dec_rs2_i == slot_rd[i]) raw = 1'b1;
                if (writes_rd && dec_rd_i != '0 && dec_rd_i == slot_rd[i]) waw = 1'b1;
            end
        end
        // No bypass: a result written this cycle is readable only next cycle.
        if (alu_v) begin
            if (dec_rs1_i != '0 && dec_rs1_i == alu_rd) raw = 1'b1;
            if (dec_rs2_i != '0 && dec_rs2_i == alu_rd) raw = 1'b1;
        end
        port   = ~dec_is_mul_i & dec_we_i & slot_v[MUL_LATENCY-2];
        stall  = reset_n & dec_valid_i & (raw | waw | port);
        issue  = reset_n & dec_valid_i & ~stall;
        mul_go = issue & dec_is_mul_i;
        alu_go = issue & ~dec_is_mul_i & dec_we_i;
    end

    assign stall_o     = stall;
    assign mul_issue_o = mul_go;
    assign mul_busy_o  = |slot_v;
    assign error_o     = error_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_v  <= '0;
            alu_v   <= 1'b0;
            alu_rd  <= '0;
            error_q <= 1'b0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                slot_rd[i] <= '0;
            end
        end else begin
            slot_v     <= {slot_v[MUL_LATENCY-2:0], mul_go};
            slot_rd[0] <= mul_go ? dec_rd_i : '0;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                slot_rd[i] <= slot_rd[i-1];
            end
            alu_v  <= alu_go;
            alu_rd <= alu_go ? dec_rd_i : '0;
            if (mul_valid_i != slot_v[LAST]) begin
                error_q <= 1'b1;
            end
        end
    end

    always_comb begin
        wb_valid  = 1'b0;
        wb_rd_o   = '0;
        wb_data_o = '0;
        if (slot_v[LAST]) begin
            wb_rd_o   = slot_rd[LAST];
            wb_data_o = mul_result_i;
            wb_valid  = mul_valid_i & (slot_rd[LAST] != '0);
        end else if (alu_v) begin
            wb_rd_o   = alu_rd;
            wb_data_o = alu_result_i;
            wb_valid  = (alu_rd != '0);
        end
    end

    assign wb_valid_o = wb_valid & reset_n;

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_mul_issue_sched
// Brief   : Directed scenarios plus randomized traffic against a cycle-log model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mul_issue_sched;
    localparam int L = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dec_valid_i = 1'b0, dec_is_mul_i = 1'b0, dec_we_i = 1'b0;
    logic [4:0]  dec_rd_i = '0, dec_rs1_i = '0, dec_rs2_i = '0;
    logic        stall_o, mul_issue_o, wb_valid_o, mul_busy_o, error_o;
    logic [31:0] alu_result_i = '0, mul_result_i = '0, wb_data_o;
    logic        mul_valid_i = 1'b0;
    logic [4:0]  wb_rd_o;

    mul_issue_sched #(.MUL_LATENCY(L), .REG_ADDR(5), .WD_SIZE(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .dec_valid_i(dec_valid_i), .dec_is_mul_i(dec_is_mul_i), .dec_we_i(dec_we_i),
        .dec_rd_i(dec_rd_i), .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i),
        .stall_o(stall_o), .mul_issue_o(mul_issue_o),
        .alu_result_i(alu_result_i), .mul_valid_i(mul_valid_i), .mul_result_i(mul_result_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .mul_busy_o(mul_busy_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Model: what issued in each cycle, indexed by cycle number mod 64.
    int         cyc = 0;
    bit         lg_mul [64];
    logic [4:0] lg_mrd [64];
    bit         lg_alu [64];
    logic [4:0] lg_ard [64];
    bit         err_m = 0;

    bit          exp_stall, exp_issue, exp_go, exp_busy, exp_err, exp_wbv, due_mul;
    logic [4:0]  exp_wbrd;
    logic [31:0] exp_wbd;

    task automatic model_eval();
        bit r = 0, w = 0, p;
        int idx;
        logic [4:0] due_rd, a_rd;
        bit due_alu;
        exp_busy = 0;
        for (int k = 1; k <= L; k++) begin
            idx = (cyc - k) & 63;
            if (lg_mul[idx]) begin
                exp_busy = 1;
                if (dec_rs1_i != 0 && dec_rs1_i == lg_mrd[idx]) r = 1;
                if (dec_rs2_i != 0 && dec_rs2_i == lg_mrd[idx]) r = 1;
                if ((dec_is_mul_i || dec_we_i) && dec_rd_i != 0 && dec_rd_i == lg_mrd[idx]) w = 1;
            end
        end
        idx = (cyc - 1) & 63;
        due_alu = lg_alu[idx];
        a_rd = lg_ard[idx];
        if (due_alu && ((dec_rs1_i != 0 && dec_rs1_i == a_rd) || (dec_rs2_i != 0 && dec_rs2_i == a_rd))) r = 1;
        p = !dec_is_mul_i && dec_we_i && lg_mul[(cyc - (L - 1)) & 63];
        exp_stall = reset_n && dec_valid_i && (r || w || p);
        exp_go    = reset_n && dec_valid_i && !exp_stall;
        exp_issue = exp_go && dec_is_mul_i;
        idx = (cyc - L) & 63;
        due_mul = lg_mul[idx];
        due_rd  = lg_mrd[idx];
        if (due_mul) begin
            exp_wbrd = due_rd; exp_wbd = mul_result_i;
            exp_wbv  = reset_n && mul_valid_i && due_rd != 0;
        end else if (due_alu) begin
            exp_wbrd = a_rd; exp_wbd = alu_result_i;
            exp_wbv  = reset_n && a_rd != 0;
        end else begin
            exp_wbrd = 0; exp_wbd = 0; exp_wbv = 0;
        end
        exp_err = err_m;
    endtask

    task automatic model_commit();
        int idx = cyc & 63;
        if (!reset_n) begin
            for (int k = 0; k < 64; k++) begin
                lg_mul[k] = 0; lg_alu[k] = 0; lg_mrd[k] = 0; lg_ard[k] = 0;
            end
            err_m = 0;
        end else begin
            lg_mul[idx] = exp_go && dec_is_mul_i;
            lg_mrd[idx] = dec_rd_i;
            lg_alu[idx] = exp_go && !dec_is_mul_i && dec_we_i;
            lg_ard[idx] = dec_rd_i;
            if (mul_valid_i != due_mul) err_m = 1;
        end
    endtask

    task automatic drive(input logic v, input logic m, input logic w,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        dec_valid_i = v; dec_is_mul_i = m; dec_we_i = w;
        dec_rd_i = d; dec_rs1_i = s1; dec_rs2_i = s2;
    endtask

    // mv_mode: 0 = well-behaved multiplier, 1 = force valid high, 2 = force low
    task automatic settle(input int mv_mode, input logic [31:0] mres);
        case (mv_mode)
            0:       mul_valid_i = lg_mul[(cyc - L) & 63];
            1:       mul_valid_i = 1'b1;
            default: mul_valid_i = 1'b0;
        endcase
        mul_result_i = mres;
        alu_result_i = $urandom;
        #2;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        settle(0, 0);
        advance();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1, 1, 1, 5, 1, 2);
        settle(0, 0);
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", stall_o); end
        tests_run++; if (mul_issue_o !== 1'b0) begin tests_failed++; $display("FAIL reset_issue: got %b want 0", mul_issue_o); end
        advance();
        settle(0, 0);
        tests_run++; if (wb_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_wbv: got %b want 0", wb_valid_o); end
        tests_run++; if (mul_busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", mul_busy_o); end
        tests_run++; if (error_o !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", error_o); end
        advance();
        reset_n = 1'b1;
    endtask

    task automatic test_single_mul();
        drive(1, 1, 0, 5, 0, 0);
        settle(0, 32'h0000_0F00);
        tests_run++; if (mul_issue_o !== 1'b1) begin tests_failed++; $display("FAIL single_issue: got %b want 1", mul_issue_o); end
        advance();
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= L + 1; k++) begin
            settle(0, 32'h0000_0F00);
            tests_run++; if (mul_busy_o !== (k <= L)) begin tests_failed++; $display("FAIL single_busy k=%0d: got %b want %b", k, mul_busy_o, (k <= L)); end
            tests_run++; if (wb_valid_o !== (k == L)) begin tests_failed++; $display("FAIL single_wbv k=%0d: got %b want %b", k, wb_valid_o, (k == L)); end
            if (k == L) begin
                tests_run++; if (wb_rd_o !== 5'd5) begin tests_failed++; $display("FAIL single_wbrd: got %0d want 5", wb_rd_o); end
                tests_run++; if (wb_data_o !== 32'h0F00) begin tests_failed++; $display("FAIL single_wbdata: got %h want 00000f00", wb_data_o); end
            end
            advance();
        end
        tests_run++; if (error_o !== 1'b0) begin tests_failed++; $display("FAIL single_err: got %b want 0", error_o); end
    endtask

    task automatic test_raw();
        drive(1, 1, 0, 5, 0, 0);
        settle(0, 0);
        advance();
        drive(1, 0, 1, 9, 5, 0);
        for (int k = 1; k <= L + 1; k++) begin
            settle(0, 0);
            tests_run++; if (stall_o !== (k <= L)) begin tests_failed++; $display("FAIL raw_stall k=%0d: got %b want %b", k, stall_o, (k <= L)); end
            advance();
        end
        drive(0, 0, 0, 0, 0, 0);
        settle(0, 0);
        tests_run++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd9 || wb_data_o !== alu_result_i) begin
            tests_failed++; $display("FAIL raw_alu_wb: got v=%b rd=%0d d=%h want v=1 rd=9 d=%h", wb_valid_o, wb_rd_o, wb_data_o, alu_result_i);
        end
        advance();
    endtask

    task automatic test_port();
        drive(1, 1, 0, 3, 0, 0);
        settle(0, 0);
        advance();
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= L - 2; k++) begin settle(0, 0); advance(); end
        drive(1, 0, 1, 7, 1, 2);
        settle(0, 0);
        tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL port_stall: got %b want 1", stall_o); end
        advance();
        settle(0, 32'h1234_5678);
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL port_release: got %b want 0", stall_o); end
        tests_run++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd3) begin tests_failed++; $display("FAIL port_mul_wb: got v=%b rd=%0d want v=1 rd=3", wb_valid_o, wb_rd_o); end
        advance();
        drive(0, 0, 0, 0, 0, 0);
        settle(0, 0);
        tests_run++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd7) begin tests_failed++; $display("FAIL port_alu_wb: got v=%b rd=%0d want v=1 rd=7", wb_valid_o, wb_rd_o); end
        advance();
        // A non-writing instruction is neither port- nor WAW-stalled.
        drive(1, 1, 0, 3, 0, 0);
        settle(0, 0);
        advance();
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= L - 2; k++) begin settle(0, 0); advance(); end
        drive(1, 0, 0, 3, 1, 2);
        settle(0, 0);
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL port_nowrite: got %b want 0", stall_o); end
        advance();
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin settle(0, 0); advance(); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k <= L + 6; k++) begin
            if (k < 6) drive(1, 1, 0, 5'(k + 1), 0, 0);
            else       drive(0, 0, 0, 0, 0, 0);
            settle(0, 32'hA000 + 32'(k));
            if (k < 6) begin
                tests_run++; if (stall_o !== 1'b0 || mul_issue_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_issue k=%0d: got stall=%b issue=%b want 0/1", k, stall_o, mul_issue_o); end
            end
            if (k >= L && k <= L + 5) begin
                tests_run++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'(k - L + 1)) begin tests_failed++; $display("FAIL b2b_wb k=%0d: got v=%b rd=%0d want v=1 rd=%0d", k, wb_valid_o, wb_rd_o, k - L + 1); end
            end
            advance();
        end
    endtask

    task automatic test_error();
        drive(0, 0, 0, 0, 0, 0);
        settle(1, 32'hDEAD);
        tests_run++; if (wb_valid_o !== 1'b0) begin tests_failed++; $display("FAIL err_wbv: got %b want 0", wb_valid_o); end
        tests_run++; if (error_o !== 1'b0) begin tests_failed++; $display("FAIL err_before: got %b want 0", error_o); end
        advance();
        for (int k = 0; k < 3; k++) begin
            settle(0, 0);
            tests_run++; if (error_o !== 1'b1) begin tests_failed++; $display("FAIL err_sticky k=%0d: got %b want 1", k, error_o); end
            advance();
        end
        do_reset();
        settle(0, 0);
        tests_run++; if (error_o !== 1'b0) begin tests_failed++; $display("FAIL err_clear: got %b want 0", error_o); end
        advance();
    endtask

    task automatic test_x0();
        drive(1, 1, 0, 0, 0, 0);
        settle(0, 0);
        tests_run++; if (mul_issue_o !== 1'b1) begin tests_failed++; $display("FAIL x0_issue: got %b want 1", mul_issue_o); end
        advance();
        drive(1, 0, 1, 0, 0, 0);
        settle(0, 0);
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL x0_stall: got %b want 0", stall_o); end
        advance();
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 2; k <= L + 1; k++) begin
            settle(0, 0);
            tests_run++; if (wb_valid_o !== 1'b0) begin tests_failed++; $display("FAIL x0_wbv k=%0d: got %b want 0", k, wb_valid_o); end
            advance();
        end
        tests_run++; if (error_o !== 1'b0) begin tests_failed++; $display("FAIL x0_err: got %b want 0", error_o); end
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 0, 4, 0, 0); settle(0, 0); advance();
        drive(1, 1, 0, 6, 0, 0); settle(0, 0); advance();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0); settle(0, 0); advance();
        reset_n = 1'b1;
        for (int k = 0; k <= L + 1; k++) begin
            settle(0, 0);
            tests_run++; if (mul_busy_o !== 1'b0 || wb_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid k=%0d: got busy=%b wbv=%b want 0/0", k, mul_busy_o, wb_valid_o); end
            advance();
        end
        tests_run++; if (error_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_err: got %b want 0", error_o); end
    endtask

    task automatic test_random();
        logic hv = 0, hm = 0, hw = 0;
        logic [4:0] hd = 0, h1 = 0, h2 = 0;
        bit held = 0;
        int mode;
        for (int n = 0; n < 1500; n++) begin
            if (!held) begin
                hv = ($urandom_range(0, 9) < 7);
                hm = ($urandom_range(0, 9) < 4);
                hw = $urandom_range(0, 1);
                hd = 5'($urandom_range(0, 7));
                h1 = 5'($urandom_range(0, 7));
                h2 = 5'($urandom_range(0, 7));
            end
            reset_n = ($urandom_range(0, 149) != 0);
            drive(hv, hm, hw, hd, h1, h2);
            mode = ($urandom_range(0, 399) == 0) ? int'($urandom_range(1, 2)) : 0;
            settle(mode, $urandom);
            tests_run++; if (stall_o !== exp_stall) begin tests_failed++; $display("FAIL rnd_stall n=%0d: got %b want %b", n, stall_o, exp_stall); end
            tests_run++; if (mul_issue_o !== exp_issue) begin tests_failed++; $display("FAIL rnd_issue n=%0d: got %b want %b", n, mul_issue_o, exp_issue); end
            tests_run++; if (wb_valid_o !== exp_wbv) begin tests_failed++; $display("FAIL rnd_wbv n=%0d: got %b want %b", n, wb_valid_o, exp_wbv); end
            tests_run++; if (wb_rd_o !== exp_wbrd) begin tests_failed++; $display("FAIL rnd_wbrd n=%0d: got %0d want %0d", n, wb_rd_o, exp_wbrd); end
            tests_run++; if (wb_data_o !== exp_wbd) begin tests_failed++; $display("FAIL rnd_wbdata n=%0d: got %h want %h", n, wb_data_o, exp_wbd); end
            tests_run++; if (mul_busy_o !== exp_busy) begin tests_failed++; $display("FAIL rnd_busy n=%0d: got %b want %b", n, mul_busy_o, exp_busy); end
            tests_run++; if (error_o !== exp_err) begin tests_failed++; $display("FAIL rnd_err n=%0d: got %b want %b", n, error_o, exp_err); end
            tests_run++; if (dut.slot_v[L-1] && dut.alu_v) begin tests_failed++; $display("FAIL rnd_dual_valid n=%0d: got both sources valid want at most one", n); end
            held = exp_stall;
            advance();
        end
        reset_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 64; k++) begin
            lg_mul[k] = 0; lg_alu[k] = 0; lg_mrd[k] = 0; lg_ard[k] = 0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_single_mul();
        test_raw();
        test_port();
        test_back_to_back();
        test_error();
        test_x0();
        test_reset_mid();
        do_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire
